hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller: the backward-direction partner of the ID/EX stage register.
- Watches the operands of the instruction in ID and the state of the instruction in EX.
- Drives stall, flush and freeze controls back into the PC, IF/ID and ID/EX registers and forward into the EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken-branch/jump redirects and data-memory wait states; also keeps saturating stall/flush performance counters and a memory-timeout watchdog.

Parameters:
- FLUSH_LEN, 1, cycles IF/ID and ID/EX are flushed per redirect (1..15).
- TIMEOUT, 256, consecutive mem_busy cycles before mem_timeout is raised (≥2).
- CNT_W, 32, width of the performance counters.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  synchronous active-high reset.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination of the instruction in EX.
- ex_is_load  in  1  EX instruction is a load (wb_select = memory).
- ex_pc_sel  in  1  EX resolved a taken branch/jump this cycle.
- mem_busy  in  1  data memory not ready; MEM stage must hold.
- pc_stall  out  1  PC holds its value.
- ifid_stall  out  1  IF/ID register holds.
- ifid_flush  out  1  IF/ID loads a bubble.
- idex_flush  out  1  ID/EX loads a bubble (all control fields zero).
- pipe_freeze  out  1  ID/EX, EX/MEM and MEM/WB hold.
- mem_timeout  out  1  sticky watchdog error.
- stall_count  out  CNT_W  cycles with pc_stall=1.
- flush_count  out  CNT_W  cycles with a redirect flush.

Behaviour:
- Reset: sys_rst=1 at a rising edge sets state=RUN and clears flush_cnt, wd_cnt, mem_timeout, stall_count and flush_count. While sys_rst=1, all combinational outputs are forced to 0. Reset mid-FLUSH or mid-wait abandons that operation immediately.
- Load-use hazard: lu = ex_is_load & (ex_rd≠0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Redirect: redir = ex_pc_sel | (state==FLUSH).
- Outputs are combinational from state and inputs, with priority in this order:
  1. mem_busy=1: pipe_freeze=1, pc_stall=1, ifid_stall=1. Both flushes are 0, even if redir or lu is true. A pending redirect stays visible because ID/EX is frozen.
  2. redir: ifid_flush=1, idex_flush=1, pc_stall=0 (the PC loads the target). lu is ignored because the ID instruction is wrong-path.
  3. lu: pc_stall=1, ifid_stall=1, idex_flush=1. Exactly one bubble is inserted; the next cycle ex_is_load=0, so the stall releases with no state change.
  4. Otherwise all outputs are 0.
- FSM states: RUN and FLUSH.
  - RUN → FLUSH when ex_pc_sel & !mem_busy & FLUSH_LEN>1; load flush_cnt=FLUSH_LEN-1.
  - FLUSH: when mem_busy=1, flush_cnt holds. Otherwise flush_cnt decrements, and state returns to RUN when flush_cnt==1.
  - ex_pc_sel during FLUSH is ignored (EX holds a bubble).
  - With FLUSH_LEN=1 the FSM never leaves RUN.
- Watchdog:
  - wd_cnt increments each cycle mem_busy=1 and clears when mem_busy=0.
  - wd_cnt saturates at TIMEOUT-1.
  - mem_timeout is set on the cycle mem_busy=1 with wd_cnt==TIMEOUT-1, i.e. it is visible after the TIMEOUT-th consecutive busy cycle. It stays set until reset.
- Counters (all registered, saturating at all-ones, never wrap):
  - stall_count increments on every edge where pc_stall=1.
  - flush_count increments on every edge where redir & !mem_busy.
- Latency: hazard responses are zero-cycle (same cycle as the inputs). Counters and mem_timeout update at the next edge.

Decomposition:
- Shared package/include: FSM state encodings (RUN=0, FLUSH=1) and a REG_ZERO=5'd0 constant.
- The XLEN width macro is not needed here.
- One sub-module is natural: sat_counter (parameter W, inputs inc/clr, saturating). Instantiate it twice for stall_count and flush_count.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for one cycle → pc_stall=ifid_stall=idex_flush=1 that cycle; next cycle (ex_is_load=0) all 0; stall_count=1.
- x0 and unused operands: ex_rd=0 with id_rs1=0, then ex_rd=7 with id_rs2=7 and id_rs2_used=0 → no stall either cycle.
- Redirect, FLUSH_LEN=3: ex_pc_sel pulse at cycle 10 → ifid_flush=idex_flush=1 in cycles 10–12, pc_stall=0; state back to RUN at edge ending 12; flush_count=3. Repeat with lu also true in cycle 10 → still no pc_stall.
- Memory wait mid-flush: FLUSH_LEN=3, mem_busy=1 in cycles 11–13 → cycles 11–13 show pipe_freeze=pc_stall=ifid_stall=1 and no flush; flushes resume in cycles 14–15; flush_count=3; stall_count=3.
- Watchdog, TIMEOUT=4: mem_busy held 3 cycles then dropped → mem_timeout=0. Then mem_busy held 4 cycles → mem_timeout=1 after the 4th edge, remains 1 after mem_busy drops, and clears only on sys_rst.
- Reset/saturation: sys_rst asserted in the middle of a FLUSH → outputs 0 immediately, state RUN after the edge. Separately, with CNT_W=4, 20 stall cycles → stall_count=15 (no wrap).

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A source operand collides with a producer when it is actually read and names the same register.
  function automatic logic src_hit(input logic used, input logic [4:0] rs, input logic [4:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX/MEM status in, stall/flush/freeze controls and counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_pc_sel;
  logic             mem_busy;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_is_load, ex_pc_sel, mem_busy,
    input  pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze, mem_timeout,
           stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_is_load, ex_pc_sel, mem_busy,
    output pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze, mem_timeout,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module hazard_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !(&r_count)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / redirect / memory-wait hazard controller; controls are same-cycle combinational,
// counters and the watchdog flag update at the next edge.
module hazard_ctrl #(
  parameter int FLUSH_LEN = 1,
  parameter int TIMEOUT   = 256,
  parameter int CNT_W     = 32
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  hazard_ctrl_if.slave hc
);
  import hazard_ctrl_pkg::*;

  localparam int             WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT - 1);
  localparam logic [3:0]      FL_INIT = 4'(FLUSH_LEN - 1);

  state_e          r_state;
  logic [3:0]      r_flush_cnt;
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_mem_timeout;

  logic w_lu;
  logic w_redir;
  logic w_pc_stall;
  logic w_ifid_stall;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_pipe_freeze;

  assign w_lu = hc.ex_is_load && (hc.ex_rd != REG_ZERO) &&
                (src_hit(hc.id_rs1_used, hc.id_rs1, hc.ex_rd) ||
                 src_hit(hc.id_rs2_used, hc.id_rs2, hc.ex_rd));

  assign w_redir = hc.ex_pc_sel || (r_state == ST_FLUSH);

  // Memory wait outranks everything: nothing may be flushed while the back end is frozen.
  always_comb begin
    w_pc_stall    = 1'b0;
    w_ifid_stall  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_pipe_freeze = 1'b0;
    if (!sys_rst) begin
      if (hc.mem_busy) begin
        w_pipe_freeze = 1'b1;
        w_pc_stall    = 1'b1;
        w_ifid_stall  = 1'b1;
      end else if (w_redir) begin
        w_ifid_flush  = 1'b1;
        w_idex_flush  = 1'b1;
      end else if (w_lu) begin
        w_pc_stall    = 1'b1;
        w_ifid_stall  = 1'b1;
        w_idex_flush  = 1'b1;
      end
    end
  end

  // r_flush_cnt counts redirect cycles still owed after the one in which ex_pc_sel fired.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (hc.ex_pc_sel && !hc.mem_busy && (FLUSH_LEN > 1)) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= FL_INIT;
          end
        end
        ST_FLUSH: begin
          if (!hc.mem_busy) begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
            if (r_flush_cnt == 4'd1) begin
              r_state <= ST_RUN;
            end
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wd_cnt      <= '0;
      r_mem_timeout <= 1'b0;
    end else if (hc.mem_busy) begin
      if (r_wd_cnt == WD_MAX) begin
        r_mem_timeout <= 1'b1;
      end else begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
    end else begin
      r_wd_cnt <= '0;
    end
  end

  hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (sys_clk),
    .i_clr   (sys_rst),
    .i_inc   (w_pc_stall),
    .o_count (hc.stall_count)
  );

  hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (sys_clk),
    .i_clr   (sys_rst),
    .i_inc   (w_redir && !hc.mem_busy),
    .o_count (hc.flush_count)
  );

  assign hc.pc_stall    = w_pc_stall;
  assign hc.ifid_stall  = w_ifid_stall;
  assign hc.ifid_flush  = w_ifid_flush;
  assign hc.idex_flush  = w_idex_flush;
  assign hc.pipe_freeze = w_pipe_freeze;
  assign hc.mem_timeout = r_mem_timeout;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table vectors, directed multi-cycle sequences and random traffic vs a cycle model.
module tb_hazard_ctrl;
  localparam int FLUSH_LEN = 3;
  localparam int TIMEOUT   = 4;
  localparam int CNT_W     = 4;
  localparam int CMAX      = (1 << CNT_W) - 1;

  // Comb output vector order: {pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_LU    = 5'b11010;
  localparam logic [4:0] C_REDIR = 5'b00110;
  localparam logic [4:0] C_BUSY  = 5'b11001;

  logic sys_clk = 1'b0;
  logic sys_rst;
  int   checks   = 0;
  int   failures = 0;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  hazard_ctrl #(.FLUSH_LEN(FLUSH_LEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .hc      (hif.slave)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: redirect cycles still owed, length of current busy run, counters.
  int         m_flush_left = 0;
  int         m_busy_run   = 0;
  int         m_stall      = 0;
  int         m_flush      = 0;
  bit         m_timeout    = 1'b0;
  logic [4:0] last_comb;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       psel;
    logic       busy;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic ld, input logic psel, input logic busy,
                       input logic rst);
    hif.id_rs1      = rs1;
    hif.id_rs2      = rs2;
    hif.id_rs1_used = u1;
    hif.id_rs2_used = u2;
    hif.ex_rd       = rd;
    hif.ex_is_load  = ld;
    hif.ex_pc_sel   = psel;
    hif.mem_busy    = busy;
    sys_rst         = rst;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called at posedge+1 with inputs applied; checks comb outputs mid-cycle, then registered ones after the edge.
  task automatic tick();
    logic       lu;
    logic       redir;
    logic [4:0] exp;
    #3;
    lu = hif.ex_is_load && (hif.ex_rd != 5'd0) &&
         ((hif.id_rs1_used && hif.id_rs1 == hif.ex_rd) || (hif.id_rs2_used && hif.id_rs2 == hif.ex_rd));
    redir = hif.ex_pc_sel || (m_flush_left > 0);
    if (sys_rst)           exp = C_NONE;
    else if (hif.mem_busy) exp = C_BUSY;
    else if (redir)        exp = C_REDIR;
    else if (lu)           exp = C_LU;
    else                   exp = C_NONE;
    last_comb = {hif.pc_stall, hif.ifid_stall, hif.ifid_flush, hif.idex_flush, hif.pipe_freeze};
    check("comb_outputs", 32'(last_comb), 32'(exp));
    @(posedge sys_clk);
    if (sys_rst) begin
      m_flush_left = 0;
      m_busy_run   = 0;
      m_stall      = 0;
      m_flush      = 0;
      m_timeout    = 1'b0;
    end else begin
      if (exp[4] && m_stall < CMAX) m_stall++;
      if (redir && !hif.mem_busy && m_flush < CMAX) m_flush++;
      if (hif.mem_busy) begin
        m_busy_run++;
        if (m_busy_run >= TIMEOUT) m_timeout = 1'b1;
      end else begin
        m_busy_run = 0;
        if (m_flush_left > 0) m_flush_left--;
        else if (hif.ex_pc_sel) m_flush_left = FLUSH_LEN - 1;
      end
    end
    #1;
    check("mem_timeout", 32'(hif.mem_timeout), 32'(m_timeout));
    check("stall_count", 32'(hif.stall_count), m_stall);
    check("flush_count", 32'(hif.flush_count), m_flush);
  endtask

  task automatic do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, C_LU};
    vecs[1] = '{5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, C_LU};
    vecs[2] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, C_NONE};
    vecs[3] = '{5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, C_NONE};
    vecs[4] = '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_NONE};
    vecs[5] = '{5'd4, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_NONE};
    vecs[6] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_REDIR};
    vecs[7] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, C_REDIR};
    vecs[8] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_BUSY};
    vecs[9] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, C_BUSY};

    // Reset with every hazard input active: all controls must be 0.
    drive(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge sys_clk);
    #1;
    tick();
    check("reset_comb_zero", 32'(last_comb), 32'(C_NONE));
    check("reset_stall_count", 32'(hif.stall_count), 32'd0);
    check("reset_flush_count", 32'(hif.flush_count), 32'd0);
    check("reset_timeout", 32'(hif.mem_timeout), 32'd0);

    // Single-cycle priority table, each from a fresh reset.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd, vecs[i].ld,
            vecs[i].psel, vecs[i].busy, 1'b0);
      tick();
      check("table_comb", 32'(last_comb), 32'(vecs[i].exp));
      check("table_stall_count", 32'(hif.stall_count), 32'(vecs[i].exp[4]));
      check("table_flush_count", 32'(hif.flush_count), 32'(vecs[i].exp[2]));
    end

    // Load-use releases once the load has moved on.
    do_reset();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("lu_stall", 32'(last_comb), 32'(C_LU));
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("lu_release", 32'(last_comb), 32'(C_NONE));
    check("lu_stall_count", 32'(hif.stall_count), 32'd1);

    // Redirect flushes for FLUSH_LEN cycles, with and without a concurrent load-use.
    for (int rep = 0; rep < 2; rep++) begin
      do_reset();
      if (rep == 0) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      else          drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      check("redir_cycle0", 32'(last_comb), 32'(C_REDIR));
      for (int k = 1; k < FLUSH_LEN; k++) begin
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, (k == 1), 1'b0, 1'b0);
        tick();
        check("redir_tail", 32'(last_comb), 32'(C_REDIR));
      end
      idle();
      tick();
      check("redir_done", 32'(last_comb), 32'(C_NONE));
      check("redir_flush_count", 32'(hif.flush_count), 32'd3);
      check("redir_stall_count", 32'(hif.stall_count), 32'd0);
    end

    // Memory wait in the middle of a flush freezes and defers the remaining flush cycles.
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("wait_freeze", 32'(last_comb), 32'(C_BUSY));
    end
    for (int k = 0; k < 2; k++) begin
      idle();
      tick();
      check("wait_resume_flush", 32'(last_comb), 32'(C_REDIR));
    end
    idle();
    tick();
    check("wait_done", 32'(last_comb), 32'(C_NONE));
    check("wait_flush_count", 32'(hif.flush_count), 32'd3);
    check("wait_stall_count", 32'(hif.stall_count), 32'd3);

    // Watchdog: TIMEOUT-1 busy cycles are harmless, TIMEOUT sets a sticky flag.
    do_reset();
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    idle();
    tick();
    check("wd_short_run", 32'(hif.mem_timeout), 32'd0);
    for (int k = 0; k < TIMEOUT; k++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("wd_long_run", 32'(hif.mem_timeout), 32'(k == TIMEOUT - 1));
    end
    idle();
    tick();
    tick();
    check("wd_sticky", 32'(hif.mem_timeout), 32'd1);
    do_reset();
    check("wd_cleared", 32'(hif.mem_timeout), 32'd0);

    // Reset in the middle of a flush abandons it.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("rst_midflush_comb", 32'(last_comb), 32'(C_NONE));
    idle();
    tick();
    check("rst_midflush_run", 32'(last_comb), 32'(C_NONE));

    // Stall counter saturates at all-ones.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("stall_saturate", 32'(hif.stall_count), 32'(CMAX));

    // Random traffic against the model; small register range forces frequent collisions.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0),
            (hif.mem_busy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0)),
            ($urandom_range(0, 149) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
